sigmoid_seq: RTL and testbench
==============================

# sigmoid_seq

Multi-cycle piecewise sigmoid evaluator for the neural-network datapath. It accepts one signed Q8.8 activation and classifies |x| into a segment. It drives the 3-bit segment select to the external combinational coefficient tables (term1/term2/term3) and evaluates the truncated series with one shared 16x16 multiplier. It returns sigmoid(x) in Q8.8 through a valid/ready output port.

## Interface
- `FRAC`, 8, fractional bits of all Q-format values; all shifts below are by `FRAC`.
- `SAT_SEG`, 6, integer part of |x| at or above which the output saturates.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input sample `x_i` valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `x_i`  in  16  signed Q8.8 activation.
- `seg_o`  out  3  segment select to the coefficient tables (0..5 = int(|x|), 6 = saturated).
- `c1_i`, `c2_i`, `c3_i`  in  16 each  signed Q8.8 coefficients for `seg_o`: constant, linear and square term.
- `out_valid`  out  1  result valid, held until taken.
- `out_ready`  in  1  consumer accepts result.
- `y_o`  out  16  signed Q8.8 sigmoid result, range 0x0000..0x0100.

## Operation
- Accept rule: accept when `in_valid && in_ready` at a clock edge.
- Registered on accept:
  - `neg` = x[15].
  - `a` = |x|, saturating: x = 0x8000 gives a = 0x7FFF.
  - `seg` = min(a[15:8], 6), driven on `seg_o`.
- FSM states: IDLE → MSQ → MC2 → MC3 → SUM → OUT → IDLE. Every transition except IDLE→MSQ and OUT→IDLE is unconditional.
  - MSQ: `a2 = (a*a) >>> 8`, 32-bit product. Sample `c1_i`, `c2_i`, `c3_i` into registers at the end of this cycle. `seg_o` has been stable for one full cycle by then.
  - MC2: `p2 = (c2*a) >>> 8`, signed 32-bit product, truncated to 18 bits.
  - MC3: `p3 = (c3*a2) >>> 8`, same width rules as MC2.
  - SUM: `s = c1 + p2 + p3` in 18-bit signed, then clamped to [0x0000, 0x0100].
    - If seg == 6, force s = 0x0100; the products are ignored.
    - `y = neg ? 0x0100 - s : s`.
    - x = 0x0000 is treated as positive.
  - OUT: `out_valid` = 1 and `y_o` is held until `out_ready`; then return to IDLE.
- Arithmetic shifts round toward −∞. Intermediate overflow beyond 18 bits is not checked: coefficient tables must keep |c1|+|p2|+|p3| < 2^17.
- `x_i` and the coefficient inputs are don't-care outside their sampling cycles.
- One transaction in flight; no input buffering.

## Timing
- Reset values: state IDLE, `out_valid` 0, `y_o` 0x0000, `seg_o` 0, all internal registers 0.
- While `rst` is high, `in_ready` is 0. From the first clock after release, `in_ready` is 1.
- Latency is fixed at 4 cycles for every input, including saturated segments. With the accept edge at E0:
  - `seg_o` is valid after E0.
  - Coefficients are sampled at E1.
  - `out_valid` and `y_o` are valid after E4.
- Throughput: with `out_ready` tied high, one result per 6 cycles. The next accept is possible at E6.
- `in_ready` is combinational from state (IDLE only). `in_valid` outside IDLE is ignored and not queued.
- Back-pressure: in OUT with `out_ready` low, `y_o`, `out_valid` and `seg_o` stay constant indefinitely.
- Reset asserted mid-transaction aborts it immediately. No `out_valid` is produced for the aborted sample.
- `y_o` keeps its last value after `out_valid` falls, until the next SUM.

## Test plan
- Linear term: bench tables c1=0x0080, c2=0x0040, c3=0; x=0x0000 → seg_o=0, y=0x0080. Then x=0x0100 → seg_o=1, y=0x00C0. `out_valid` rises exactly 4 cycles after each accept.
- Symmetry: same tables, x=0xFF00 (−1.0) → seg_o=1, y=0x0040. Also x=0xFF80 (−0.5) → seg_o=0, y=0x0060.
- Square term: c1=0, c2=0, c3=0x0010, x=0x0200 → a2=0x0400, seg_o=2, y=0x0040. Then c1=0x00F0, c3=0x0020, same x → clamp gives y=0x0100.
- Saturation: x=0x0700 → seg_o=6, y=0x0100 regardless of coefficients. x=0x8000 → y=0x0000. x=0x05FF → seg_o=5 and uses the table values.
- Handshake: hold `out_ready` low 10 cycles while pulsing `in_valid`. `y_o` stays stable, `in_ready` stays 0 and no extra input is consumed. Release `out_ready`: one transfer, then `in_ready` high the next cycle.
- Reset: assert `rst` asynchronously mid-edge while in MC2. `out_valid`=0, `y_o`=0 and `seg_o`=0 immediately. After release, a fresh sample gives a correct result with latency 4.

Source files
------------

// File: rtl/sigmoid_if.sv
// Handshake and coefficient-table bus between a sigmoid producer/consumer and sigmoid_seq.
// Ports: in_valid/in_ready/x_i (input sample), seg_o/c1_i/c2_i/c3_i (table lookup),
//        out_valid/out_ready/y_o (result). The slave modport is the evaluator side.
interface sigmoid_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_i;
  logic [2:0]  seg_o;
  logic [15:0] c1_i;
  logic [15:0] c2_i;
  logic [15:0] c3_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y_o;

  modport slave (
    input  in_valid, x_i, c1_i, c2_i, c3_i, out_ready,
    output in_ready, seg_o, out_valid, y_o
  );

  modport master (
    output in_valid, x_i, c1_i, c2_i, c3_i, out_ready,
    input  in_ready, seg_o, out_valid, y_o
  );
endinterface

// File: rtl/sigmoid_seq.sv
// Piecewise sigmoid in Q8.8: y = c1 + c2*|x| + c3*|x|^2 per segment, mirrored for x < 0.
// Latency 4 cycles accept-to-out_valid; one sample in flight, next accept 6 cycles apart.
// Backpressure: result, out_valid and seg_o hold in OUT until out_ready; in_ready only in IDLE.
// Ports: clk/rst (async active-high); bus = sigmoid_if.slave (input handshake, segment
//        select to the external coefficient tables, coefficient inputs, output handshake).
module sigmoid_seq #(
  parameter int FRAC    = 8,
  parameter int SAT_SEG = 6
) (
  input logic      clk,
  input logic      rst,
  sigmoid_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MSQ, MC2, MC3, SUM, OUT} state_t;

  state_t state, state_nxt;

  logic               neg;
  logic        [15:0] a;
  logic        [2:0]  seg;
  logic signed [15:0] a2;
  logic signed [15:0] c1, c2, c3;
  logic signed [17:0] p2, p3;
  logic        [15:0] y;

  logic               accept;
  logic        [15:0] x_abs;
  logic        [2:0]  x_seg;
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] prod;
  logic signed [31:0] prod_sh;
  logic signed [17:0] s_raw;
  logic        [15:0] s_clamp;
  logic        [15:0] y_nxt;
  logic               unused_prod;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == OUT);
  assign bus.seg_o     = seg;
  assign bus.y_o       = y;

  assign accept = bus.in_valid && bus.in_ready;

  // |x| saturates at 0x7FFF so that -128.0 lands in the saturated segment.
  always_comb begin
    x_abs = bus.x_i;
    if (bus.x_i[15]) x_abs = (bus.x_i == 16'h8000) ? 16'h7FFF : 16'(-bus.x_i);
  end

  assign x_seg = (x_abs[15:8] >= 8'(SAT_SEG)) ? 3'(SAT_SEG) : x_abs[10:8];

  // Single shared multiplier; operands are steered by the current state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MSQ: begin mul_a = a;  mul_b = a;  end
      MC2: begin mul_a = c2; mul_b = a;  end
      MC3: begin mul_a = c3; mul_b = a2; end
      default: ;
    endcase
  end

  assign prod    = mul_a * mul_b;
  assign prod_sh = prod >>> FRAC;  // floor division, i.e. rounds toward -inf

  // Only the low 18 bits of the shifted product are carried forward.
  assign unused_prod = ^prod_sh[31:18];

  // Overflow beyond 18 bits is excluded by the table design, so a plain wrap-around add suffices.
  assign s_raw = {{2{c1[15]}}, c1} + p2 + p3;

  always_comb begin
    s_clamp = s_raw[15:0];
    if (seg == 3'(SAT_SEG))      s_clamp = 16'h0100;
    else if (s_raw < 18'sd0)     s_clamp = 16'h0000;
    else if (s_raw > 18'sd256)   s_clamp = 16'h0100;
    y_nxt = neg ? (16'h0100 - s_clamp) : s_clamp;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MSQ;
      MSQ:     state_nxt = MC2;
      MC2:     state_nxt = MC3;
      MC3:     state_nxt = SUM;
      SUM:     state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg <= 1'b0;
      a   <= '0;
      seg <= '0;
      a2  <= '0;
      c1  <= '0;
      c2  <= '0;
      c3  <= '0;
      p2  <= '0;
      p3  <= '0;
      y   <= '0;
    end else begin
      if (accept) begin
        neg <= bus.x_i[15];
        a   <= x_abs;
        seg <= x_seg;
      end
      // seg_o has been driven for a full cycle by the end of MSQ, so the tables have settled.
      if (state == MSQ) begin
        a2 <= prod_sh[15:0];
        c1 <= bus.c1_i;
        c2 <= bus.c2_i;
        c3 <= bus.c3_i;
      end
      if (state == MC2) p2 <= prod_sh[17:0];
      if (state == MC3) p3 <= prod_sh[17:0];
      if (state == SUM) y  <= y_nxt;
    end
  end

endmodule

// File: tb/tb_sigmoid_seq.sv
module tb_sigmoid_seq;
  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  sigmoid_if bus();

  sigmoid_seq #(.FRAC(8), .SAT_SEG(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic set_tab(input logic [15:0] c1, input logic [15:0] c2, input logic [15:0] c3);
    bus.c1_i = c1;
    bus.c2_i = c2;
    bus.c3_i = c3;
  endtask

  // Drives one sample through with out_ready high; returns observed seg, latency and result.
  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  task automatic do_txn(input logic [15:0] x, output logic [2:0] seg, output int lat,
                        output logic [15:0] y);
    bus.x_i       = x;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x_i      = 16'hDEAD;
    seg = bus.seg_o;
    lat = -1;
    y   = 16'hxxxx;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = k;
        y   = bus.y_o;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.y_o !== 16'h0000) $display("FAIL rst_y: got %h want 0000", bus.y_o); else passed++;
    total++; if (bus.seg_o !== 3'd0) $display("FAIL rst_seg: got %0d want 0", bus.seg_o); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_release_in_ready: got %b want 1", bus.in_ready); else passed++;
  endtask

  task automatic test_linear();
    logic [2:0]  seg;
    logic [15:0] y;
    int          lat;
    set_tab(16'h0080, 16'h0040, 16'h0000);
    do_txn(16'h0000, seg, lat, y);
    total++; if (seg !== 3'd0) $display("FAIL lin0_seg: got %0d want 0", seg); else passed++;
    total++; if (lat != 4) $display("FAIL lin0_latency: got %0d want 4", lat); else passed++;
    total++; if (y !== 16'h0080) $display("FAIL lin0_y: got %h want 0080", y); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL lin0_out_valid_drop: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL lin0_in_ready_back: got %b want 1", bus.in_ready); else passed++;
    do_txn(16'h0100, seg, lat, y);
    total++; if (seg !== 3'd1) $display("FAIL lin1_seg: got %0d want 1", seg); else passed++;
    total++; if (lat != 4) $display("FAIL lin1_latency: got %0d want 4", lat); else passed++;
    total++; if (y !== 16'h00C0) $display("FAIL lin1_y: got %h want 00c0", y); else passed++;
  endtask

  task automatic test_symmetry();
    logic [2:0]  seg;
    logic [15:0] y;
    int          lat;
    set_tab(16'h0080, 16'h0040, 16'h0000);
    do_txn(16'hFF00, seg, lat, y);
    total++; if (seg !== 3'd1) $display("FAIL sym_m1_seg: got %0d want 1", seg); else passed++;
    total++; if (y !== 16'h0040) $display("FAIL sym_m1_y: got %h want 0040", y); else passed++;
    do_txn(16'hFF80, seg, lat, y);
    total++; if (seg !== 3'd0) $display("FAIL sym_mhalf_seg: got %0d want 0", seg); else passed++;
    total++; if (y !== 16'h0060) $display("FAIL sym_mhalf_y: got %h want 0060", y); else passed++;
    total++; if (lat != 4) $display("FAIL sym_mhalf_latency: got %0d want 4", lat); else passed++;
  endtask

  // c2 = -1 LSB times a = 1 LSB gives -1/256, which floors to -1 (not 0).
  task automatic test_rounding();
    logic [2:0]  seg;
    logic [15:0] y;
    int          lat;
    set_tab(16'h0080, 16'hFFFF, 16'h0000);
    do_txn(16'h0001, seg, lat, y);
    total++; if (y !== 16'h007F) $display("FAIL round_floor_y: got %h want 007f", y); else passed++;
  endtask

  task automatic test_square();
    logic [2:0]  seg;
    logic [15:0] y;
    int          lat;
    set_tab(16'h0000, 16'h0000, 16'h0010);
    do_txn(16'h0200, seg, lat, y);
    total++; if (seg !== 3'd2) $display("FAIL sq_seg: got %0d want 2", seg); else passed++;
    total++; if (lat != 4) $display("FAIL sq_latency: got %0d want 4", lat); else passed++;
    total++; if (y !== 16'h0040) $display("FAIL sq_y: got %h want 0040", y); else passed++;
    set_tab(16'h00F0, 16'h0000, 16'h0020);
    do_txn(16'h0200, seg, lat, y);
    total++; if (y !== 16'h0100) $display("FAIL sq_clamp_y: got %h want 0100", y); else passed++;
  endtask

  task automatic test_saturation();
    logic [2:0]  seg;
    logic [15:0] y;
    int          lat;
    set_tab(16'hF000, 16'h7FFF, 16'h8000);
    do_txn(16'h0700, seg, lat, y);
    total++; if (seg !== 3'd6) $display("FAIL sat_pos_seg: got %0d want 6", seg); else passed++;
    total++; if (lat != 4) $display("FAIL sat_pos_latency: got %0d want 4", lat); else passed++;
    total++; if (y !== 16'h0100) $display("FAIL sat_pos_y: got %h want 0100", y); else passed++;
    do_txn(16'h8000, seg, lat, y);
    total++; if (seg !== 3'd6) $display("FAIL sat_min_seg: got %0d want 6", seg); else passed++;
    total++; if (y !== 16'h0000) $display("FAIL sat_min_y: got %h want 0000", y); else passed++;
    set_tab(16'h00F8, 16'h0001, 16'h0000);
    do_txn(16'h05FF, seg, lat, y);
    total++; if (seg !== 3'd5) $display("FAIL seg5_seg: got %0d want 5", seg); else passed++;
    total++; if (y !== 16'h00FD) $display("FAIL seg5_y: got %h want 00fd", y); else passed++;
  endtask

  task automatic test_handshake();
    int seen;
    set_tab(16'h0080, 16'h0040, 16'h0000);
    bus.out_ready = 1'b0;
    bus.x_i       = 16'h0100;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        seen = k;
        break;
      end
    end
    total++; if (seen != 4) $display("FAIL hs_latency: got %0d want 4", seen); else passed++;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.x_i      = 16'h0400 + 16'(i);
      @(posedge clk); #1;
      total++; if (bus.y_o !== 16'h00C0) $display("FAIL hs_hold_y[%0d]: got %h want 00c0", i, bus.y_o); else passed++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL hs_hold_in_ready[%0d]: got %b want 0", i, bus.in_ready); else passed++;
      total++; if (bus.out_valid !== 1'b1 || bus.seg_o !== 3'd1)
        $display("FAIL hs_hold_vld_seg[%0d]: got vld=%b seg=%0d want vld=1 seg=1", i, bus.out_valid, bus.seg_o);
      else passed++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL hs_release_vld: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL hs_release_in_ready: got %b want 1", bus.in_ready); else passed++;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid || !bus.in_ready) seen++;
    end
    total++; if (seen != 0) $display("FAIL hs_no_extra_txn: got %0d busy cycles want 0", seen); else passed++;
  endtask

  task automatic test_reset_abort();
    logic [2:0]  seg;
    logic [15:0] y;
    int          lat;
    int          seen;
    set_tab(16'h0080, 16'h0040, 16'h0000);
    bus.out_ready = 1'b1;
    bus.x_i       = 16'h0300;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++; if (bus.seg_o !== 3'd3) $display("FAIL abort_pre_seg: got %0d want 3", bus.seg_o); else passed++;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL abort_vld: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.y_o !== 16'h0000) $display("FAIL abort_y: got %h want 0000", bus.y_o); else passed++;
    total++; if (bus.seg_o !== 3'd0) $display("FAIL abort_seg: got %0d want 0", bus.seg_o); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL abort_in_ready: got %b want 0", bus.in_ready); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    total++; if (seen != 0) $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); else passed++;
    do_txn(16'h0100, seg, lat, y);
    total++; if (lat != 4) $display("FAIL abort_fresh_latency: got %0d want 4", lat); else passed++;
    total++; if (y !== 16'h00C0) $display("FAIL abort_fresh_y: got %h want 00c0", y); else passed++;
    total++; if (seg !== 3'd1) $display("FAIL abort_fresh_seg: got %0d want 1", seg); else passed++;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.x_i       = 16'h0000;
    set_tab(16'h0000, 16'h0000, 16'h0000);
    test_reset();
    test_linear();
    test_symmetry();
    test_rounding();
    test_square();
    test_saturation();
    test_handshake();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
